// File: rtl/branch_predictor_bht_if.sv
// branch_predictor_bht_if: fetch/execute branch signals between the pipeline and the BHT predictor
interface branch_predictor_bht_if #(parameter int AWIDTH = 32);
  logic [AWIDTH-1:0] pc_f;
  logic Br_f, Br_x, BrTrue, stall, flush;
  logic BrPred_f, BrPred_x, mispredict_x;
  modport master(output pc_f, Br_f, Br_x, BrTrue, stall, flush, input BrPred_f, BrPred_x, mispredict_x);
  modport slave(input pc_f, Br_f, Br_x, BrTrue, stall, flush, output BrPred_f, BrPred_x, mispredict_x);
endinterface

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: 2-bit saturating-counter BHT with F->X pipe; BHT_BYPASS_EN forwards same-cycle updates to fetch
module branch_predictor_bht #(
  parameter int AWIDTH = 32,
  parameter int IDX_BITS = 6
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_bht_if.slave bus
);
  localparam int DEPTH = 1 << IDX_BITS;
  logic [1:0] ctr [DEPTH];
  logic [1:0] ctr_x, ctr_nxt, ctr_rd;
  logic [IDX_BITS-1:0] idx_f, idx_x;
  logic valid_x, pred_x, upd;
  logic unused_pc;
  assign idx_f = bus.pc_f[IDX_BITS+1:2];
  assign unused_pc = ^{bus.pc_f[AWIDTH-1:IDX_BITS+2], bus.pc_f[1:0]};
  assign upd = bus.Br_x & valid_x & ~bus.stall;
  always_comb begin
    ctr_x = ctr[idx_x];
    ctr_nxt = bus.BrTrue ? (&ctr_x ? ctr_x : ctr_x + 2'd1) : (|ctr_x ? ctr_x - 2'd1 : ctr_x);
`ifdef BHT_BYPASS_EN
    ctr_rd = (upd && idx_f == idx_x) ? ctr_nxt : ctr[idx_f];
`else
    ctr_rd = ctr[idx_f];
`endif
  end
  assign bus.BrPred_f = bus.Br_f & ctr_rd[1];
  assign bus.BrPred_x = pred_x & valid_x;
  assign bus.mispredict_x = bus.Br_x & valid_x & (bus.BrTrue != bus.BrPred_x);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b01;
    else if (upd)
      ctr[idx_x] <= ctr_nxt;
  // flush squashes only the fetch slot; idx_x is kept so it stays a don't-care
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_x <= 1'b0;
      pred_x <= 1'b0;
      idx_x <= '0;
    end else if (!bus.stall) begin
      valid_x <= bus.flush ? 1'b0 : bus.Br_f;
      pred_x <= bus.flush ? 1'b0 : bus.BrPred_f;
      idx_x <= bus.flush ? idx_x : idx_f;
    end
endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 Parameter AWIDTH, 32, PC width in bits.
REQ-002 Parameter IDX_BITS, 6, BHT index width; table depth = 2^IDX_BITS entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_f  input  AWIDTH  PC of the instruction in the fetch stage.
REQ-006 Br_f  input  1  fetch-stage instruction is a conditional branch (opcode 1100011).
REQ-007 Br_x  input  1  execute-stage instruction is a conditional branch.
REQ-008 BrTrue  input  1  resolved branch outcome in execute; valid only when Br_x=1.
REQ-009 stall  input  1  load-use stall; fetch and execute stages hold.
REQ-010 flush  input  1  execute-stage redirect; the fetch-stage instruction is squashed.
REQ-011 BrPred_f  output  1  fetch-stage taken prediction; drives redirect to the branch target.
REQ-012 BrPred_x  output  1  prediction made for the instruction now in execute.
REQ-013 mispredict_x  output  1  Br_x & valid_x & (BrTrue != BrPred_x).

Function
REQ-014 Table: 2^IDX_BITS 2-bit saturating counters, indexed by pc_f[IDX_BITS+1:2]; 0/1 = not-taken, 2/3 = taken.
REQ-015 BrPred_f = Br_f & ctr[idx_f][1]; combinational, zero latency from pc_f/Br_f.
REQ-016 F->X pipeline register holds {valid_x, pred_x, idx_x}; BrPred_x = pred_x & valid_x.
REQ-017 Register behaviour on each edge, highest priority first: stall=1 -> hold all fields; flush=1 -> valid_x=0, pred_x=0, idx_x unchanged; otherwise load valid_x=Br_f, pred_x=BrPred_f, idx_x=idx_f.
REQ-018 Update condition: Br_x & valid_x & ~stall; on the edge, ctr[idx_x] increments (saturates at 3) when BrTrue=1 and decrements (saturates at 0) when BrTrue=0.
REQ-019 Only one counter is written per cycle; all other entries hold.
REQ-020 An update is not suppressed by flush, because flush squashes only the fetch-stage instruction, never the resolving branch in execute.
REQ-021 Same-index read/write in one cycle (idx_f == idx_x with the update active): behaviour is set by REQ-027/REQ-028.
REQ-022 A branch resolved while stall=1 is updated exactly once, on the first edge with stall=0.
REQ-023 Aliasing: distinct PCs sharing an index share a counter; no tag check.

Reset
REQ-024 While rst_n=0, asynchronously: every counter = 2'b01 (weakly not-taken); valid_x=0; pred_x=0; idx_x=0.
REQ-025 Outputs during reset: BrPred_x=0, mispredict_x=0; BrPred_f=0, because every counter reads 01.
REQ-026 Assertion of rst_n mid-operation discards any in-flight update; the first update after deassertion applies to the reset counter values.

Configuration
REQ-027 Macro BHT_BYPASS_EN defined: on a same-index collision, BrPred_f is taken from the bit [1] of the counter's post-update value, so the fetch stage sees the write in the same cycle.
REQ-028 Macro BHT_BYPASS_EN undefined: BrPred_f uses the stored (pre-update) counter value; the new value is visible from the next cycle.

Verification
REQ-029 Reset, then pc_f=0x100, Br_f=1 -> BrPred_f=0; one cycle later BrPred_x=0; all counters read 01.
REQ-030 Same branch PC resolved taken twice (Br_x=1, BrTrue=1), stall=0 -> counter 01->10->11; next fetch of that PC gives BrPred_f=1. Four more taken resolutions -> counter stays 11.
REQ-031 Counter at 11, prediction taken, resolution BrTrue=0 -> mispredict_x=1 in that cycle; counter becomes 10; next prediction for that PC is still 1.
REQ-032 stall=1 held for 3 cycles with Br_x=1 -> idx_x, pred_x and all counters unchanged for the 3 cycles; exactly one update on release.
REQ-033 flush=1 with Br_f=1 at pc 0x200 -> next cycle valid_x=0, BrPred_x=0, and no counter update is made for 0x200.
REQ-034 Same-index collision (idx_f == idx_x, counter 01, BrTrue=1) -> BrPred_f=1 with BHT_BYPASS_EN defined, BrPred_f=0 with it undefined.
